// File: rtl/arith_pipe_pkg.sv
// Shared opcode definitions for the arith_pipe block and anything that drives it.
package arith_pipe_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SUB = 2'd0,
        OP_ADD = 2'd1,
        OP_AND = 2'd2,
        OP_ACC = 2'd3
    } op_e;

endpackage

// File: rtl/arith_pipe_if.sv
// Valid/ready request and response channels of arith_pipe.
interface arith_pipe_if
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e              in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_equal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_equal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_equal
    );
endinterface

// File: rtl/arith_pipe_alu.sv
// Combinational datapath: one result per opcode plus the operand-equality flag.
module arith_pipe_alu
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LSB_MASK = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             equal
);

    always_comb begin
        result = '0;
        case (op)
            OP_SUB: result = a - b;
            OP_ADD: begin
                result = a + b;
                if (LSB_MASK != 0) result[0] = 1'b0;
            end
            OP_AND: result = a & b;
            OP_ACC: result = acc + (a & b);
            default: result = '0;
        endcase
        equal = (a == b);
    end

endmodule

// File: rtl/arith_pipe.sv
// Two-stage valid/ready arithmetic pipeline: stage 1 holds operands, stage 2 holds the result.
module arith_pipe
    import arith_pipe_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 2,
    parameter int LSB_MASK    = 1
) (
    input  logic          clk,
    input  logic          reset,
    arith_pipe_if.slave   bus
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    op_e              r_s1_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic             r_out_equal;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_equal;

    assign w_s2_load    = !r_out_valid || bus.out_ready;
    assign bus.in_ready = !r_s1_valid || w_s2_load;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_equal  = r_out_equal;

    arith_pipe_alu #(
        .WIDTH    (WIDTH),
        .LSB_MASK (LSB_MASK)
    ) u_alu (
        .a      (r_s1_a),
        .b      (r_s1_b),
        .op     (r_s1_op),
        .acc    (r_acc),
        .result (w_alu_result),
        .equal  (w_alu_equal)
    );

    // acc moves only when an ACC result lands in stage 2, so back-to-back ACCs chain naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_equal  <= 1'b0;
            r_acc        <= WIDTH'(RESET_VALUE);
        end else begin
            if (bus.in_ready) r_s1_valid <= bus.in_valid;
            if (w_s2_load) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_result <= w_alu_result;
                    r_out_equal  <= w_alu_equal;
                    if (r_s1_op == OP_ACC) r_acc <= w_alu_result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a  <= bus.in_a;
            r_s1_b  <= bus.in_b;
            r_s1_op <= bus.in_op;
        end
    end

endmodule

// File: tb/tb_arith_pipe.sv
// Scoreboard bench for arith_pipe: expected results are queued on accept and popped on each output handshake.
module tb_arith_pipe;
    import arith_pipe_pkg::*;

    localparam int WIDTH       = 4;
    localparam int RESET_VALUE = 2;
    localparam int LSB_MASK    = 1;
    localparam int M           = 1 << WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arith_pipe_if #(.WIDTH(WIDTH)) bus();

    arith_pipe #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .LSB_MASK    (LSB_MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int result;
        bit equal;
    } exp_t;

    exp_t sb_q[$];
    int   model_acc = RESET_VALUE % M;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   hold_pending = 0;
    int   hold_res;
    bit   hold_eq;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Reference: plain modular arithmetic on integers, acc advanced in transaction order.
    function automatic exp_t ref_model(int a, int b, int op);
        exp_t e;
        int   r;
        case (op)
            0: r = (a - b + M) % M;
            1: begin
                r = (a + b) % M;
                if (LSB_MASK != 0) r = r - (r % 2);
            end
            2: r = a & b;
            default: begin
                model_acc = (model_acc + (a & b)) % M;
                r = model_acc;
            end
        endcase
        e.result = r;
        e.equal  = (a == b);
        return e;
    endfunction

    // Monitor: sample at negedge, i.e. the values present at the following rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            model_acc    = RESET_VALUE % M;
            hold_pending = 0;
        end else begin
            if (hold_pending && bus.out_valid) begin
                check("hold_result", 32'(bus.out_result), 32'(hold_res));
                check("hold_equal", 32'(bus.out_equal), 32'(hold_eq));
            end
            hold_pending = bus.out_valid && !bus.out_ready;
            hold_res     = int'(bus.out_result);
            hold_eq      = bus.out_equal;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result %0d, required no output", bus.out_result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_result", 32'(bus.out_result), 32'(e.result));
                    check("out_equal", 32'(bus.out_equal), 32'(e.equal));
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb_q.push_back(ref_model(int'(bus.in_a), int'(bus.in_b), int'(bus.in_op)));
        end
    end

    task automatic send(int a, int b, int op);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a[WIDTH-1:0];
        bus.in_b     = b[WIDTH-1:0];
        bus.in_op    = op_e'(op[1:0]);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0 && !bus.out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_SUB;
        bus.out_ready = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_result", 32'(bus.out_result), 32'd0);
        check("rst_out_equal", 32'(bus.out_equal), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;

        // SUB 3-5 with exact two-cycle latency.
        send(3, 5, 0);
        @(negedge clk);
        check("lat_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
        check("sub_3_5_result", 32'(bus.out_result), 32'hE);
        check("sub_3_5_equal", 32'(bus.out_equal), 32'd0);
        drain();

        send(7, 6, 1);
        send(9, 9, 1);
        drain();

        // ACC chain from a fresh reset, then AND must not disturb acc.
        pulse_reset();
        bus.out_ready = 1'b1;
        send(15, 15, 3);
        send(15, 15, 3);
        send(15, 15, 3);
        send(12, 10, 2);
        send(0, 0, 3);
        drain();

        // Stall: continuous input, output blocked for 5 cycles.
        bus.out_ready = 1'b0;
        nacc = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_a     = 4'd1;
        bus.in_b     = 4'd14;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.in_ready) nacc++;
            @(posedge clk);
            #1;
            bus.in_a = WIDTH'(nacc + 1);
            bus.in_b = WIDTH'(14 - nacc);
        end
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_accepts", 32'(nacc), 32'd2);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset with both stages full; the ACC already in stage 2 has moved acc.
        bus.out_ready = 1'b0;
        send(7, 7, 3);
        send(3, 3, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_stale_out_valid", 32'(bus.out_valid), 32'd0);
        end
        send(0, 0, 3);
        drain();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_a      = WIDTH'($urandom_range(0, M - 1));
            bus.in_b      = ($urandom_range(0, 4) == 0) ? bus.in_a : WIDTH'($urandom_range(0, M - 1));
            bus.in_op     = op_e'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
